// File: rtl/mips_pkg.sv
// Shared MIPS fetch-stage definitions: address geometry, default reset vector
// and the PC sequencer state encoding.
package mips_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [ADDR_W-1:0] RESET_VECTOR_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        PCS_BOOT = 2'd0,
        PCS_RUN  = 2'd1,
        PCS_HALT = 2'd2
    } pcs_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control interface between the pipeline control (master) and the PC
// sequencer (slave).
interface pc_sequencer_if
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W
);

    logic             stall;
    logic             halt;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_seq;
    logic             pc_valid;
    logic             redirect_pend;
    logic             misalign_err;

    modport master (
        output stall, halt, redirect_valid, redirect_target,
        input  pc, pc_seq, pc_valid, redirect_pend, misalign_err
    );

    modport slave (
        input  stall, halt, redirect_valid, redirect_target,
        output pc, pc_seq, pc_valid, redirect_pend, misalign_err
    );

endinterface

// File: rtl/pc_incrementer.sv
// Combinational sequential-fetch successor: pc + STEP, wrapping modulo 2^WIDTH.
module pc_incrementer
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W,
    parameter int unsigned STEP  = INSTR_BYTES
) (
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_seq_c
);

    // Carry out of the MSB is discarded, giving the modulo wrap.
    assign pc_seq_c = pc + WIDTH'(STEP);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the MIPS fetch stage: stall, redirect with
// capture during stall, halt and misaligned-target rejection.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned     WIDTH        = ADDR_W,
    parameter int unsigned     STEP         = INSTR_BYTES,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEFAULT)
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    // Low address bits that must be zero for a STEP-aligned target.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    pcs_state_e       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             pend_q, pend_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] pc_seq_c;
    logic             aligned_c;
    logic             redir_ok_c;

    pc_incrementer #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_inc (
        .pc       (pc_q),
        .pc_seq_c (pc_seq_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PCS_BOOT;
            pc_q       <= RESET_VECTOR;
            pend_tgt_q <= '0;
            pend_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_d     = pend_q;
        valid_d    = valid_q;
        err_d      = 1'b0;
        aligned_c  = (bus.redirect_target & ALIGN_MASK) == '0;
        redir_ok_c = bus.redirect_valid & aligned_c;

        unique case (state_q)
            PCS_BOOT: begin
                state_d = PCS_RUN;
                valid_d = 1'b1;
            end
            PCS_RUN: begin
                if (bus.halt) begin
                    state_d = PCS_HALT;
                    valid_d = 1'b0;
                    pend_d  = 1'b0;
                end else begin
                    err_d = bus.redirect_valid & ~aligned_c;
                    if (bus.stall) begin
                        // Latest redirect seen during a stall wins.
                        if (redir_ok_c) begin
                            pend_tgt_d = bus.redirect_target;
                            pend_d     = 1'b1;
                        end
                    end else if (redir_ok_c) begin
                        pc_d   = bus.redirect_target;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = pend_tgt_q;
                        pend_d = 1'b0;
                    end else begin
                        pc_d = pc_seq_c;
                    end
                end
            end
            PCS_HALT: begin
            end
            default: begin
                state_d = PCS_BOOT;
            end
        endcase
    end

    assign bus.pc            = pc_q;
    assign bus.pc_seq        = pc_seq_c;
    assign bus.pc_valid      = valid_q;
    assign bus.redirect_pend = pend_q;
    assign bus.misalign_err  = err_q;

endmodule
